// File: rtl/approx_mul_pkg.sv
// approx_mul_pkg: shared FSM states, kernel codes and step constants for approx_mul_seq.
// ap2/ap4 skip the low 2/4 product bits and drive them to ones to offset truncation bias.
package approx_mul_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  localparam logic [1:0] KSEL_EXACT = 2'b00;
  localparam logic [1:0] KSEL_AP2 = 2'b01;
  localparam logic [1:0] KSEL_AP4 = 2'b10;
  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_LH = 2'd1;
  localparam logic [1:0] STEP_HL = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;
  localparam logic [3:0] SHIFT_LL = 4'd0;
  localparam logic [3:0] SHIFT_LH = 4'd4;
  localparam logic [3:0] SHIFT_HL = 4'd4;
  localparam logic [3:0] SHIFT_HH = 4'd8;
  function automatic logic [3:0] step_shift(input logic [1:0] k);
    return k == STEP_LL ? SHIFT_LL : k == STEP_LH ? SHIFT_LH : k == STEP_HL ? SHIFT_HL : SHIFT_HH;
  endfunction
endpackage

// File: rtl/approx_pp_unit.sv
// approx_pp_unit: combinational 4x4 partial product with exact/ap2/ap4 kernel select.
module approx_pp_unit
  import approx_mul_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] sel,
  output logic [7:0] pp
);
  logic [7:0] exact, ap2, ap4;
  assign exact = {4'b0, a} * {4'b0, b};
  assign ap2 = exact | 8'h03;
  assign ap4 = exact | 8'h0F;
  // reserved code 11 falls through to exact
  assign pp = sel == KSEL_EXACT ? exact : sel == KSEL_AP2 ? ap2 : sel == KSEL_AP4 ? ap4 : exact;
endmodule

// File: rtl/approx_mul_seq.sv
// approx_mul_seq: 8x8 approximate multiplier, one shared 4x4 kernel over four steps.
module approx_mul_seq
  import approx_mul_pkg::*;
#(
  parameter bit SAT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_a,
  input  logic [7:0]  in_b,
  input  logic [7:0]  cfg_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_prod,
  output logic        out_sat
);
  state_t state, state_nx;
  logic [1:0] k;
  logic [7:0] a_q, b_q, mode_q;
  logic [16:0] acc;
  logic [7:0] pp;
  approx_pp_unit u_pp (
    .a  (k[1] ? a_q[7:4] : a_q[3:0]),
    .b  (k[0] ? b_q[7:4] : b_q[3:0]),
    .sel(mode_q[{k, 1'b0} +: 2]),
    .pp (pp)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (in_valid ? MUL : IDLE)
             : state == MUL ? (k == STEP_HH ? DONE : MUL)
             : (out_ready ? IDLE : DONE);
  end
  always_comb begin
    in_ready = state == IDLE;
    out_valid = state == DONE;
    out_sat = acc[16];
    out_prod = (SAT_EN && acc[16]) ? 16'hFFFF : acc[15:0];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k <= STEP_LL;
      acc <= '0;
      a_q <= '0;
      b_q <= '0;
      mode_q <= '0;
    end else if (state == IDLE && in_valid) begin
      k <= STEP_LL;
      acc <= '0;
      a_q <= in_a;
      b_q <= in_b;
      mode_q <= cfg_mode;
    end else if (state == MUL) begin
      acc <= acc + (17'(pp) << step_shift(k));
      k <= k + 2'd1;
    end
endmodule

// File: tb/tb_approx_mul_seq.sv
// tb_approx_mul_seq: vector table, corner sequences and random ops against an error-term model.
module tb_approx_mul_seq;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_a = 0, in_b = 0, cfg_mode = 0;
  logic in_ready, out_valid, out_sat, in_ready0, out_valid0, out_sat0;
  logic [15:0] out_prod, out_prod0;
  int checks = 0, errors = 0, lat;

  typedef struct {
    logic [7:0] a, b, m;
    int prod, prod0, sat;
  } vec_t;
  vec_t vt[$];

  always #5 clk = ~clk;

  approx_mul_seq #(.SAT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .cfg_mode(cfg_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_prod(out_prod), .out_sat(out_sat));

  approx_mul_seq #(.SAT_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .cfg_mode(cfg_mode), .out_valid(out_valid0),
    .out_ready(out_ready), .out_prod(out_prod0), .out_sat(out_sat0));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int apx(input int p, input logic [1:0] c);
    return c == 2'b01 ? (p | 3) : c == 2'b10 ? (p | 15) : p;
  endfunction

  // exact product plus the shifted error each approximate kernel adds
  function automatic int model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    int s;
    int sh[4];
    int an, bn, p;
    sh = '{0, 4, 4, 8};
    s = int'(a) * int'(b);
    for (int i = 0; i < 4; i++) begin
      an = i >= 2 ? int'(a[7:4]) : int'(a[3:0]);
      bn = (i % 2) == 1 ? int'(b[7:4]) : int'(b[3:0]);
      p = an * bn;
      s += (apx(p, m[2*i +: 2]) - p) << sh[i];
    end
    return s;
  endfunction

  task automatic start(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m);
    int n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready timeout", 0, 1);
    in_a = a; in_b = b; cfg_mode = m; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    while (!out_valid && l < 20) begin
      @(negedge clk);
      l++;
    end
    if (!out_valid) chk("out_valid timeout", 0, 1);
  endtask

  task automatic finish_op();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int e;
    vt.push_back('{8'd3,   8'd5,   8'h00, 15,    15,    0});
    vt.push_back('{8'd200, 8'd150, 8'h00, 30000, 30000, 0});
    vt.push_back('{8'd255, 8'd255, 8'h00, 65025, 65025, 0});
    vt.push_back('{8'h0F,  8'h0F,  8'h01, 227,   227,   0});
    vt.push_back('{8'h0F,  8'h0F,  8'h02, 239,   239,   0});
    vt.push_back('{8'h0F,  8'h0F,  8'h03, 225,   225,   0});
    vt.push_back('{8'h10,  8'h10,  8'h40, 768,   768,   0});
    vt.push_back('{8'h01,  8'h10,  8'h08, 240,   240,   0});
    vt.push_back('{8'h20,  8'h03,  8'h10, 112,   112,   0});
    vt.push_back('{8'h00,  8'h00,  8'h55, 867,   867,   0});
    vt.push_back('{8'hFF,  8'hFF,  8'hFF, 65025, 65025, 0});
    vt.push_back('{8'hFF,  8'hFF,  8'hAA, 65535, 3535,  1});

    repeat (2) @(negedge clk);
    chk("reset in_ready", int'(in_ready), 1);
    chk("reset out_valid", int'(out_valid), 0);
    chk("reset out_prod", int'(out_prod), 0);
    chk("reset out_sat", int'(out_sat), 0);
    rst_n = 1;
    @(negedge clk);

    start(8'hFF, 8'hFF, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 0;
    #1;
    chk("midreset out_valid", int'(out_valid), 0);
    chk("midreset in_ready", int'(in_ready), 1);
    chk("midreset out_prod", int'(out_prod), 0);
    chk("midreset out_prod0", int'(out_prod0), 0);
    chk("midreset out_sat", int'(out_sat), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    foreach (vt[i]) begin
      start(vt[i].a, vt[i].b, vt[i].m);
      wait_done(lat);
      chk($sformatf("vec%0d latency", i), lat, 4);
      chk($sformatf("vec%0d out_prod", i), int'(out_prod), vt[i].prod);
      chk($sformatf("vec%0d out_prod nosat", i), int'(out_prod0), vt[i].prod0);
      chk($sformatf("vec%0d out_sat", i), int'(out_sat), vt[i].sat);
      chk($sformatf("vec%0d out_sat nosat", i), int'(out_sat0), vt[i].sat);
      finish_op();
    end

    start(8'hFF, 8'hFF, 8'h00);
    cfg_mode = 8'h55;
    wait_done(lat);
    chk("cfg latch out_prod", int'(out_prod), 65025);
    finish_op();
    cfg_mode = 8'h00;

    start(8'd17, 8'd13, 8'h00);
    wait_done(lat);
    in_a = 8'd2; in_b = 8'd2; in_valid = 1;
    repeat (10) begin
      @(negedge clk);
      chk("bp out_prod", int'(out_prod), 221);
      chk("bp in_ready", int'(in_ready), 0);
      chk("bp out_valid", int'(out_valid), 1);
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("bp idle in_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 0;
    chk("bp accepted", int'(in_ready), 0);
    wait_done(lat);
    chk("bp2 latency", lat, 4);
    chk("bp2 out_prod", int'(out_prod), 4);
    finish_op();

    start(8'd1, 8'd1, 8'h00);
    force dut.pp = 8'hFF;
    force dut0.pp = 8'hFF;
    wait_done(lat);
    chk("force out_prod", int'(out_prod), 65535);
    chk("force out_sat", int'(out_sat), 1);
    chk("force out_prod nosat", int'(out_prod0), 16'h1FDF);
    chk("force out_sat nosat", int'(out_sat0), 1);
    release dut.pp;
    release dut0.pp;
    finish_op();

    repeat (60) begin
      logic [7:0] a, b, m;
      a = 8'($urandom); b = 8'($urandom); m = 8'($urandom);
      e = model(a, b, m);
      start(a, b, m);
      wait_done(lat);
      chk($sformatf("rand %0d*%0d m=%0h out_prod", a, b, m), int'(out_prod), e > 65535 ? 65535 : e);
      chk($sformatf("rand %0d*%0d m=%0h out_prod nosat", a, b, m), int'(out_prod0), e & 16'hFFFF);
      chk($sformatf("rand %0d*%0d m=%0h out_sat", a, b, m), int'(out_sat), int'(e > 65535));
      finish_op();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
